// File: rtl/mmio_timer.sv
// mmio_timer: memory-mapped 32-bit timer with compare/match, one-shot or auto-reload mode and a level irq.
// Optional prescaler enabled by defining MMIO_TIMER_PRESCALER_EN. Revision 1.0.
`default_nettype none

package mmio_timer_pkg;
  typedef enum logic [1:0] {
    MEM_DT_BYTE = 2'd0,
    MEM_DT_HALF = 2'd1,
    MEM_DT_WORD = 2'd2
  } mem_dt_e;

  typedef enum logic [1:0] {
    ENONE  = 2'd0,
    EALIGN = 2'd1,
    EINVAL = 2'd2
  } errno_e;
endpackage

module mmio_timer
  import mmio_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wd,
  input  logic        d_we,
  input  mem_dt_e     d_dt,
  output logic [31:0] d_rd,
  output errno_e      err,
  output logic        sel,
  output logic        irq
);

`ifdef MMIO_TIMER_PRESCALER_EN
  localparam int ADDR_LSB = 5;
`else
  localparam int ADDR_LSB = 4;
`endif
  localparam int IDX_W = ADDR_LSB - 2;

  localparam logic [IDX_W-1:0] REG_CTRL   = IDX_W'(0);
  localparam logic [IDX_W-1:0] REG_CMP    = IDX_W'(1);
  localparam logic [IDX_W-1:0] REG_CNT    = IDX_W'(2);
  localparam logic [IDX_W-1:0] REG_STATUS = IDX_W'(3);
`ifdef MMIO_TIMER_PRESCALER_EN
  localparam logic [IDX_W-1:0] REG_PRESC  = IDX_W'(4);
`endif

  logic        en_q, en_d;
  logic        auto_q, auto_d;
  logic        irq_en_q, irq_en_d;
  logic [31:0] cmp_q, cmp_d;
  logic [31:0] cnt_q, cnt_d;
  logic        match_q, match_d;

  logic [IDX_W-1:0] idx;
  logic             legal;
  logic             misaligned;
  logic             wr_en;
  logic             tick;
  logic             match_hit;
  logic [31:0]      reg_rd;

  assign sel        = (d_addr[31:ADDR_LSB] == BASE_ADDR[31:ADDR_LSB]);
  assign idx        = d_addr[ADDR_LSB-1:2];
  assign misaligned = (d_addr[1:0] != 2'b00);
  assign legal      = (d_dt == MEM_DT_WORD) && !misaligned;
  assign wr_en      = d_we && sel && legal;

`ifdef MMIO_TIMER_PRESCALER_EN
  logic [15:0] presc_q, presc_d;
  logic [15:0] pc_q, pc_d;

  assign tick = en_q && (pc_q == presc_q);

  always_comb begin
    pc_d = pc_q + 16'd1;
    if (!en_q || tick) begin
      pc_d = '0;
    end
  end
`else
  assign tick = en_q;
`endif

  assign match_hit = tick && (cnt_q == cmp_q);

  always_comb begin
    en_d     = en_q;
    auto_d   = auto_q;
    irq_en_d = irq_en_q;
    cmp_d    = cmp_q;
    cnt_d    = cnt_q;
    match_d  = match_q;
`ifdef MMIO_TIMER_PRESCALER_EN
    presc_d  = presc_q;
`endif

    if (tick) begin
      if (match_hit) begin
        match_d = 1'b1;
        if (auto_q) begin
          cnt_d = '0;
        end else begin
          en_d = 1'b0;
        end
      end else begin
        cnt_d = cnt_q + 32'd1;
      end
    end

    // CPU stores override the tick; a W1C loses to a same-cycle match.
    if (wr_en) begin
      case (idx)
        REG_CTRL: begin
          en_d     = d_wd[0];
          auto_d   = d_wd[1];
          irq_en_d = d_wd[2];
        end
        REG_CMP:    cmp_d = d_wd;
        REG_CNT:    cnt_d = d_wd;
        REG_STATUS: begin
          if (d_wd[0] && !match_hit) begin
            match_d = 1'b0;
          end
        end
`ifdef MMIO_TIMER_PRESCALER_EN
        REG_PRESC:  presc_d = d_wd[15:0];
`endif
        default: ;
      endcase
    end
  end

  always_comb begin
    reg_rd = '0;
    case (idx)
      REG_CTRL:   reg_rd = {29'd0, irq_en_q, auto_q, en_q};
      REG_CMP:    reg_rd = cmp_q;
      REG_CNT:    reg_rd = cnt_q;
      REG_STATUS: reg_rd = {31'd0, match_q};
`ifdef MMIO_TIMER_PRESCALER_EN
      REG_PRESC:  reg_rd = {16'd0, presc_q};
`endif
      default:    reg_rd = '0;
    endcase
  end

  always_comb begin
    d_rd = '0;
    err  = ENONE;
    if (sel) begin
      if (legal) begin
        d_rd = reg_rd;
      end else if (misaligned) begin
        err = EALIGN;
      end else begin
        err = EINVAL;
      end
    end
  end

  assign irq = match_q && irq_en_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      en_q     <= 1'b0;
      auto_q   <= 1'b0;
      irq_en_q <= 1'b0;
      cmp_q    <= '0;
      cnt_q    <= '0;
      match_q  <= 1'b0;
`ifdef MMIO_TIMER_PRESCALER_EN
      presc_q  <= '0;
      pc_q     <= '0;
`endif
    end else begin
      en_q     <= en_d;
      auto_q   <= auto_d;
      irq_en_q <= irq_en_d;
      cmp_q    <= cmp_d;
      cnt_q    <= cnt_d;
      match_q  <= match_d;
`ifdef MMIO_TIMER_PRESCALER_EN
      presc_q  <= presc_d;
      pc_q     <= pc_d;
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mmio_timer.sv
// tb_mmio_timer: scoreboard bench for mmio_timer; stimulus pushes expected load responses, a monitor pops and compares.
// Revision 1.0.
`default_nettype none

module tb_mmio_timer;
  import mmio_timer_pkg::*;

  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wd = '0;
  logic        d_we = 1'b0;
  mem_dt_e     d_dt = MEM_DT_WORD;
  logic [31:0] d_rd;
  errno_e      err;
  logic        sel;
  logic        irq;

  mmio_timer #(.BASE_ADDR(BASE)) dut (
    .clk    (clk),
    .rst    (rst),
    .d_addr (d_addr),
    .d_wd   (d_wd),
    .d_we   (d_we),
    .d_dt   (d_dt),
    .d_rd   (d_rd),
    .err    (err),
    .sel    (sel),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] rd;
    errno_e      err;
    logic        sel;
    logic        irq;
  } exp_t;

  exp_t sb[$];
  logic chk_en = 1'b0;
  logic done   = 1'b0;
  int   n_chk  = 0;
  int   n_pass = 0;

  // Single bus cycle: inputs change just after a rising edge; when chk is set
  // the expected response for this cycle is queued for the monitor.
  task automatic op(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                    input mem_dt_e dt, input logic chk, input string name,
                    input logic [31:0] e_rd, input errno_e e_err, input logic e_sel,
                    input logic e_irq);
    exp_t e;
    @(posedge clk);
    #1;
    d_we   = we;
    d_addr = addr;
    d_wd   = wd;
    d_dt   = dt;
    chk_en = chk;
    if (chk) begin
      e.name = name;
      e.rd   = e_rd;
      e.err  = e_err;
      e.sel  = e_sel;
      e.irq  = e_irq;
      sb.push_back(e);
    end
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] wd);
    op(1'b1, BASE + off, wd, MEM_DT_WORD, 1'b0, "", '0, ENONE, 1'b0, 1'b0);
  endtask

  task automatic rd(input logic [31:0] off, input logic [31:0] e_rd, input logic e_irq,
                    input string name);
    op(1'b0, BASE + off, '0, MEM_DT_WORD, 1'b1, name, e_rd, ENONE, 1'b1, e_irq);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      op(1'b0, 32'h0, '0, MEM_DT_WORD, 1'b0, "", '0, ENONE, 1'b0, 1'b0);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      exp_t e;
      n_chk = n_chk + 1;
      if (sb.size() == 0) begin
        $display("FAIL scoreboard_underflow: response with no expectation queued");
      end else begin
        e = sb.pop_front();
        if (d_rd === e.rd && err === e.err && sel === e.sel && irq === e.irq) begin
          n_pass = n_pass + 1;
        end else begin
          $display("FAIL %s: got rd=%h err=%0d sel=%b irq=%b, expected rd=%h err=%0d sel=%b irq=%b",
                   e.name, d_rd, err, sel, irq, e.rd, e.err, e.sel, e.irq);
        end
      end
    end else if (done) begin
      n_chk = n_chk + 1;
      if (sb.size() == 0) begin
        n_pass = n_pass + 1;
      end else begin
        $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    rd(32'h0, 32'h0, 1'b0, "reset_ctrl");
    rd(32'h4, 32'h0, 1'b0, "reset_cmp");
    rd(32'h8, 32'h0, 1'b0, "reset_cnt");
    rd(32'hC, 32'h0, 1'b0, "reset_status");

    // One-shot: CNT reaches 5 after 5 ticks, match on the 6th stops the timer.
    wr(32'h4, 32'd5);
    wr(32'h0, 32'h5);
    idle(6);
    rd(32'h8, 32'd5, 1'b1, "oneshot_cnt");
    rd(32'hC, 32'd1, 1'b1, "oneshot_match");
    rd(32'h0, 32'h4, 1'b1, "oneshot_ctrl_en_cleared");
    wr(32'hC, 32'h0);
    rd(32'hC, 32'd1, 1'b1, "status_write0_noeffect");
    wr(32'hC, 32'h1);
    rd(32'hC, 32'd0, 1'b0, "status_w1c");
    rd(32'h8, 32'd5, 1'b0, "oneshot_cnt_held");

    // Auto-reload with CMP = 2: 0,1,2,0,1,2...
    wr(32'h4, 32'd2);
    wr(32'h8, 32'd0);
    wr(32'h0, 32'h3);
    rd(32'h8, 32'd0, 1'b0, "auto_cnt0");
    rd(32'h8, 32'd1, 1'b0, "auto_cnt1");
    rd(32'h8, 32'd2, 1'b0, "auto_cnt2");
    rd(32'h8, 32'd0, 1'b0, "auto_wrap0");
    rd(32'hC, 32'd1, 1'b0, "auto_match_set");
    rd(32'h8, 32'd2, 1'b0, "auto_cnt2_again");
    wr(32'h0, 32'h0);
    wr(32'hC, 32'h1);

    // 32-bit wrap without a match, then a CNT store colliding with a tick.
    wr(32'h4, 32'd3);
    wr(32'h8, 32'hFFFF_FFFF);
    wr(32'h0, 32'h1);
    rd(32'h8, 32'hFFFF_FFFF, 1'b0, "wrap_before");
    rd(32'h8, 32'h0, 1'b0, "wrap_to_zero");
    rd(32'hC, 32'h0, 1'b0, "wrap_no_match");
    wr(32'h8, 32'h10);
    rd(32'h8, 32'h10, 1'b0, "store_beats_tick");
    rd(32'h8, 32'h11, 1'b0, "count_after_store");
    wr(32'h0, 32'h0);

    // Illegal accesses.
    op(1'b1, BASE + 32'h4, 32'hAA, MEM_DT_BYTE, 1'b1, "byte_store_einval",
       32'h0, EINVAL, 1'b1, 1'b0);
    rd(32'h4, 32'd3, 1'b0, "cmp_unchanged");
    op(1'b0, BASE + 32'h6, 32'h0, MEM_DT_WORD, 1'b1, "misaligned_ealign",
       32'h0, EALIGN, 1'b1, 1'b0);
    op(1'b0, BASE - 32'h4, 32'h0, MEM_DT_WORD, 1'b1, "below_window",
       32'h0, ENONE, 1'b0, 1'b0);

`ifdef MMIO_TIMER_PRESCALER_EN
    rd(32'h10, 32'h0, 1'b0, "presc_reset");
    wr(32'h10, 32'd3);
    wr(32'h4, 32'd2);
    wr(32'h8, 32'd0);
    wr(32'hC, 32'h1);
    wr(32'h0, 32'h1);
    idle(11);
    rd(32'hC, 32'd0, 1'b0, "presc_no_match_yet");
    rd(32'hC, 32'd1, 1'b0, "presc_match_at_12");
    wr(32'h0, 32'h0);
`else
    op(1'b0, BASE + 32'h10, 32'h0, MEM_DT_WORD, 1'b1, "offset16_outside",
       32'h0, ENONE, 1'b0, 1'b0);
`endif

    // Reset wins over a same-edge store.
    wr(32'h0, 32'h1);
    @(posedge clk);
    #1;
    chk_en = 1'b0;
    rst    = 1'b1;
    d_we   = 1'b1;
    d_addr = BASE + 32'h4;
    d_wd   = 32'd7;
    d_dt   = MEM_DT_WORD;
    @(posedge clk);
    #1;
    rst  = 1'b0;
    d_we = 1'b0;
    rd(32'h4, 32'h0, 1'b0, "rst_beats_store");
    rd(32'h0, 32'h0, 1'b0, "rst_ctrl");
    rd(32'h8, 32'h0, 1'b0, "rst_cnt");

    @(posedge clk);
    #1;
    chk_en = 1'b0;
    done   = 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1);
  end

endmodule

`default_nettype wire
